dilate_3x3_bin: RTL and testbench
=================================

// Module: dilate_3x3_bin
// PURPOSE
//  Binary 3x3 dilation on a streaming RGB video port; the morphological dual of the erode stage.
//  - Input is a binarised pixel stream; output = OR of the 3x3 neighbourhood.
//  - Builds its own window from two internal 1-bit line buffers plus col/row counters
//    with image-border masking; no external window generator is used.
//  - Sits after binarisation in the video chain, before or after erode, to form open/close.
// PARAMETERS
//  COL     1024  active pixels per line
//  ROW     768   active lines per frame
//  THRESH  8'd128  foreground threshold, used only with DILATE_THRESH_EN
// PORTS
//  clk           in   1   pixel clock, single clock domain
//  rst_n         in   1   asynchronous active-low reset
//  RGB_de        in   1   input data enable, one pixel per clk while high
//  RGB_hsync     in   1   input hsync, delayed only
//  RGB_vsync     in   1   input vsync, active-high; rising edge starts a frame
//  RGB_data      in   24  input pixel
//  dilate_de     out  1   RGB_de delayed 3 clk
//  dilate_hsync  out  1   RGB_hsync delayed 3 clk
//  dilate_vsync  out  1   RGB_vsync delayed 3 clk
//  dilate_data   out  24  24'hFFFFFF = foreground, 24'h000000 = background
// BEHAVIOUR
//  - Reset: all outputs 0; counters, window and pipeline registers 0. Line-buffer contents are
//    don't-care because row masking hides them.
//  - Foreground bit fg = (RGB_data != 0), sampled only when RGB_de = 1.
//  - col_cnt: increments on each RGB_de beat; wraps COL-1 -> 0; on wrap, row_cnt increments.
//    row_cnt wraps ROW-1 -> 0.
//  - A rising edge of RGB_vsync forces col_cnt = row_cnt = 0, regardless of position.
//  - Counters hold while RGB_de = 0; blanking never advances them or writes the buffers.
//  - Line buffers: lb1 holds row r-1 and lb0 holds row r-2 at the current column.
//    Both read and write once per RGB_de beat: lb0 <= lb1 out, lb1 <= fg.
//  - Window: bottom-right tap is input (r,c). The window covers rows r-2..r and cols c-2..c.
//  - Masking: any tap with row < 0 or col < 0 reads 0. This applies to row_cnt < 2 for the top
//    rows and col_cnt < 2 for the left columns. Nothing from the previous line or previous frame
//    may leak into the window.
//  - Output pixel (r,c) = OR of the 9 masked taps.
//  - Pipeline, fixed latency 3 clk:
//    - clk1: window register and mask;
//    - clk2: three row-ORs;
//    - clk3: final OR, registered to dilate_data.
//  - de/hsync/vsync use a 3-stage shift register, so output sync aligns exactly with data.
//  - dilate_data is 0 whenever dilate_de = 0.
//  - Reset mid-frame: outputs 0 immediately (async). After release, output is valid from the
//    next vsync rising edge. The partial frame before that edge is not guaranteed.
//  - Line shorter than COL: a vsync edge re-aligns the counters. Behaviour inside that frame is
//    undefined but must not lock up.
// CONFIGURATION
//  DILATE_THRESH_EN defined:
//    fg = (RGB_data[7:0] >= THRESH), gray-in-all-channels convention. Adds one compare
//    before clk1; total latency stays 3 clk.
//  DILATE_THRESH_EN undefined:
//    fg = (RGB_data != 0). THRESH is unused.
// STRUCTURE
//  - Package dilate_pkg:
//    - COL_DEF = 1024, ROW_DEF = 768;
//    - PIX_FG = 24'hFFFFFF, PIX_BG = 24'h000000;
//    - DILATE_LAT = 3;
//    - counter widths via $clog2(COL), $clog2(ROW).
//  - Sub-module line_buffer_1bit: COL-deep 1-bit delay line with wr_en, instanced twice.
//    Infers RAM or SRL.
//  - Top level holds the counters, vsync edge detect, mask logic, OR pipeline and sync delays.
// TESTING
//  1. 1024x768 all-0 frame with one fg pixel at (10,10) -> dilate_data FF..FF exactly at
//     rows 10..12, cols 10..12 (9 px); all else 0.
//  2. All-0 frame -> all outputs 0. All-FFFFFF frame -> all 1024*768 outputs FFFFFF,
//     including borders.
//  3. Border: fg at (0,0) -> 1 at rows 0..2, cols 0..2.
//     fg at (5,1023) -> 1 only at rows 5..7, col 1023; (6,0) and (6,1) stay 0, proving no line
//     wrap. fg at (767,1023) -> only (767,1023); next frame row 0 is clean.
//  4. Timing: random de gaps of 1..20 clk inside lines -> each dilate_de/hsync/vsync edge
//     exactly 3 clk after input; image identical to the gap-free run.
//  5. Reset: assert rst_n = 0 at row 300 col 17 -> all outputs 0 within the same clk (async).
//     Release, send a new frame with fg at (1,1) -> output 1 only at rows 1..3, cols 1..3;
//     no stale pre-reset data.
//  6. DILATE_THRESH_EN, THRESH = 128: 24'h7F7F7F -> bg; 24'h808080 -> fg.
//     Without the macro: 24'h010101 -> fg, 24'h000000 -> bg.

Source files
------------

// File: rtl/dilate_pkg.sv
`default_nettype none
// ============================================================================
//  Module   : dilate_pkg
//  Purpose  : Shared constants, sync-bundle type and width helper for the
//             binary 3x3 dilation stage.
//  Revision : 1.0 - initial release
// ============================================================================
package dilate_pkg;

    localparam int          COL_DEF    = 1024;
    localparam int          ROW_DEF    = 768;
    localparam logic [23:0] PIX_FG     = 24'hFFFFFF;
    localparam logic [23:0] PIX_BG     = 24'h000000;
    localparam int          DILATE_LAT = 3;

    typedef struct packed {
        logic de;
        logic hsync;
        logic vsync;
    } sync_t;

    function automatic int cnt_width(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage
`default_nettype wire

// File: rtl/dilate_3x3_bin_if.sv
`default_nettype none
// ============================================================================
//  Module   : dilate_3x3_bin_if
//  Purpose  : Video stream in (RGB_*) and dilated stream out (dilate_*).
//  Revision : 1.0 - initial release
// ============================================================================
interface dilate_3x3_bin_if;

    logic        RGB_de;
    logic        RGB_hsync;
    logic        RGB_vsync;
    logic [23:0] RGB_data;
    logic        dilate_de;
    logic        dilate_hsync;
    logic        dilate_vsync;
    logic [23:0] dilate_data;

    modport master (
        output RGB_de, RGB_hsync, RGB_vsync, RGB_data,
        input  dilate_de, dilate_hsync, dilate_vsync, dilate_data
    );

    modport slave (
        input  RGB_de, RGB_hsync, RGB_vsync, RGB_data,
        output dilate_de, dilate_hsync, dilate_vsync, dilate_data
    );

endinterface
`default_nettype wire

// File: rtl/line_buffer_1bit.sv
`default_nettype none
// ============================================================================
//  Module   : line_buffer_1bit
//  Purpose  : DEPTH-deep 1-bit line delay addressed by column; read-before-write.
//  Revision : 1.0 - initial release
// ============================================================================
module line_buffer_1bit #(
    parameter int DEPTH = 1024,
    parameter int AW    = 10
) (
    input  wire logic          clk,
    input  wire logic          wr_en,
    input  wire logic [AW-1:0] addr,
    input  wire logic          din,
    output logic               dout
);

    logic r_mem [DEPTH];

    // Contents are never reset: row masking upstream hides anything stale.
    assign dout = r_mem[addr];

    always_ff @(posedge clk) begin
        if (wr_en) begin
            r_mem[addr] <= din;
        end
    end

endmodule
`default_nettype wire

// File: rtl/dilate_3x3_bin.sv
`default_nettype none
// ============================================================================
//  Module   : dilate_3x3_bin
//  Purpose  : Streaming binary 3x3 dilation, fixed 3-clk latency, border masked.
//             Optional macro DILATE_THRESH_EN: fg = RGB_data[7:0] >= THRESH.
//  Revision : 1.0 - initial release
// ============================================================================
module dilate_3x3_bin
    import dilate_pkg::*;
#(
    parameter int COL = COL_DEF,
    parameter int ROW = ROW_DEF
`ifdef DILATE_THRESH_EN
    ,
    parameter logic [7:0] THRESH = 8'd128
`endif
) (
    input wire logic        clk,
    input wire logic        rst_n,
    dilate_3x3_bin_if.slave vid
);

    localparam int                 c_col_w    = cnt_width(COL);
    localparam int                 c_row_w    = cnt_width(ROW);
    localparam logic [c_col_w-1:0] c_col_last = c_col_w'(COL - 1);
    localparam logic [c_row_w-1:0] c_row_last = c_row_w'(ROW - 1);

    logic                 w_fg;
    logic                 w_vs_rise;
    logic [c_col_w-1:0]   w_col;
    logic [c_row_w-1:0]   w_row;
    logic                 w_lb1_q;
    logic                 w_lb0_q;
    logic [2:0]           w_new_col;

    logic                 r_vs_prev;
    logic [c_col_w-1:0]   r_col_cnt;
    logic [c_row_w-1:0]   r_row_cnt;
    logic [2:0][2:0]      r_win;
    logic [2:0]           r_row_or;
    logic [23:0]          r_data;
    sync_t                r_sync [DILATE_LAT];

`ifdef DILATE_THRESH_EN
    assign w_fg = (vid.RGB_data[7:0] >= THRESH);
`else
    assign w_fg = (vid.RGB_data != 24'd0);
`endif

    // A vsync rising edge relocates the current beat to (0,0) immediately.
    assign w_vs_rise = vid.RGB_vsync & ~r_vs_prev;
    assign w_col     = w_vs_rise ? '0 : r_col_cnt;
    assign w_row     = w_vs_rise ? '0 : r_row_cnt;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_vs_prev <= 1'b0;
            r_col_cnt <= '0;
            r_row_cnt <= '0;
        end else begin
            r_vs_prev <= vid.RGB_vsync;
            if (vid.RGB_de) begin
                if (w_col == c_col_last) begin
                    r_col_cnt <= '0;
                    r_row_cnt <= (w_row == c_row_last) ? '0 : w_row + 1'b1;
                end else begin
                    r_col_cnt <= w_col + 1'b1;
                    r_row_cnt <= w_row;
                end
            end else if (w_vs_rise) begin
                r_col_cnt <= '0;
                r_row_cnt <= '0;
            end
        end
    end

    line_buffer_1bit #(.DEPTH(COL), .AW(c_col_w)) u_lb1 (
        .clk   (clk),
        .wr_en (vid.RGB_de),
        .addr  (w_col),
        .din   (w_fg),
        .dout  (w_lb1_q)
    );

    line_buffer_1bit #(.DEPTH(COL), .AW(c_col_w)) u_lb0 (
        .clk   (clk),
        .wr_en (vid.RGB_de),
        .addr  (w_col),
        .din   (w_lb1_q),
        .dout  (w_lb0_q)
    );

    // Column taps {r-2, r-1, r}, with rows above the frame forced to 0.
    assign w_new_col = {w_lb0_q & (w_row[c_row_w-1:1] != '0),
                        w_lb1_q & (w_row != '0),
                        w_fg};

    // Stage 1: window shift; at column 0 the older columns belong to the
    // previous line, so they are flushed rather than shifted.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_win <= '0;
        end else if (vid.RGB_de) begin
            r_win[2] <= w_new_col;
            r_win[1] <= (w_col == '0) ? 3'b000 : r_win[2];
            r_win[0] <= (w_col == '0) ? 3'b000 : r_win[1];
        end
    end

    // Stage 2 row ORs, stage 3 final OR gated by the aligned data enable.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_row_or <= '0;
            r_data   <= PIX_BG;
        end else begin
            for (int i = 0; i < 3; i++) begin
                r_row_or[i] <= r_win[0][i] | r_win[1][i] | r_win[2][i];
            end
            r_data <= (r_sync[DILATE_LAT-2].de && (|r_row_or)) ? PIX_FG : PIX_BG;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < DILATE_LAT; i++) begin
                r_sync[i] <= '0;
            end
        end else begin
            r_sync[0] <= {vid.RGB_de, vid.RGB_hsync, vid.RGB_vsync};
            for (int i = 1; i < DILATE_LAT; i++) begin
                r_sync[i] <= r_sync[i-1];
            end
        end
    end

    assign vid.dilate_de    = r_sync[DILATE_LAT-1].de;
    assign vid.dilate_hsync = r_sync[DILATE_LAT-1].hsync;
    assign vid.dilate_vsync = r_sync[DILATE_LAT-1].vsync;
    assign vid.dilate_data  = r_data;

endmodule
`default_nettype wire

// File: tb/tb_dilate_3x3_bin.sv
`default_nettype none
// ============================================================================
//  Module   : tb_dilate_3x3_bin
//  Purpose  : Directed frames on a reduced 16x16 image for dilate_3x3_bin.
//  Revision : 1.0 - initial release
// ============================================================================
module tb_dilate_3x3_bin;
    import dilate_pkg::*;

    localparam int c_col = 16;
    localparam int c_row = 16;

    logic clk   = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    dilate_3x3_bin_if vif ();

    dilate_3x3_bin #(.COL(c_col), .ROW(c_row)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .vid   (vif)
    );

    int          n_cmp = 0;
    int          n_err = 0;
    logic [23:0] in_img  [c_row][c_col];
    logic [23:0] out_img [c_row][c_col];
    int          orow = 0, ocol = 0, cap_cnt = 0;
    logic        prev_ovs = 1'b0;
    int          sync_err = 0, gate_err = 0;
    bit          sync_chk_en = 1'b1;
    logic [2:0]  hist [3] = '{default: 3'b000};

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    // Output monitor on the falling edge: sync delay, de gating, frame capture.
    always @(negedge clk) begin
        if (sync_chk_en && ({vif.dilate_de, vif.dilate_hsync, vif.dilate_vsync} !== hist[2]))
            sync_err++;
        hist[2] = hist[1];
        hist[1] = hist[0];
        hist[0] = {vif.RGB_de, vif.RGB_hsync, vif.RGB_vsync};
        if (!vif.dilate_de && vif.dilate_data !== 24'd0) gate_err++;
        if (vif.dilate_vsync && !prev_ovs) begin
            orow = 0; ocol = 0; cap_cnt = 0;
        end
        prev_ovs = vif.dilate_vsync;
        if (vif.dilate_de) begin
            if (orow < c_row) out_img[orow][ocol] = vif.dilate_data;
            cap_cnt++;
            ocol++;
            if (ocol == c_col) begin
                ocol = 0;
                orow++;
            end
        end
    end

    function automatic bit fg_of(input logic [23:0] p);
`ifdef DILATE_THRESH_EN
        return p[7:0] >= 8'd128;
`else
        return p != 24'd0;
`endif
    endfunction

    function automatic bit exp_px(input int r, input int c);
        bit o = 1'b0;
        for (int dr = 0; dr < 3; dr++)
            for (int dc = 0; dc < 3; dc++)
                if (r - dr >= 0 && c - dc >= 0) o |= fg_of(in_img[r-dr][c-dc]);
        return o;
    endfunction

    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    task automatic idle(input int n);
        vif.RGB_de   = 1'b0;
        vif.RGB_data = 24'd0;
        repeat (n) cyc();
    endtask

    task automatic fill_img(input logic [23:0] v);
        for (int r = 0; r < c_row; r++)
            for (int c = 0; c < c_col; c++) in_img[r][c] = v;
    endtask

    task automatic send_frame(input bit gaps, input int ab_r = -1, input int ab_c = -1);
        for (int r = 0; r < c_row; r++)
            for (int c = 0; c < c_col; c++) out_img[r][c] = 24'h5A5A5A;
        vif.RGB_vsync = 1'b1; idle(3);
        vif.RGB_vsync = 1'b0; idle(3);
        for (int r = 0; r < c_row; r++) begin
            vif.RGB_hsync = 1'b1; idle(2);
            vif.RGB_hsync = 1'b0; idle(2);
            for (int c = 0; c < c_col; c++) begin
                if (gaps && $urandom_range(0, 3) == 0) idle(int'($urandom_range(1, 20)));
                if (r == ab_r && c == ab_c) begin
                    rst_n = 1'b0;
                    #1;
                    check("rst_async_de",    32'(vif.dilate_de),    32'd0);
                    check("rst_async_hsync", 32'(vif.dilate_hsync), 32'd0);
                    check("rst_async_vsync", 32'(vif.dilate_vsync), 32'd0);
                    check("rst_async_data",  32'(vif.dilate_data),  32'd0);
                    idle(3);
                    rst_n = 1'b1;
                    idle(3);
                    return;
                end
                vif.RGB_de   = 1'b1;
                vif.RGB_data = in_img[r][c];
                cyc();
            end
        end
        idle(8);
    endtask

    task automatic check_frame(input string tag, input int exp_fg);
        int mism = 0;
        int nfg  = 0;
        for (int r = 0; r < c_row; r++)
            for (int c = 0; c < c_col; c++) begin
                if (out_img[r][c] !== (exp_px(r, c) ? PIX_FG : PIX_BG)) mism++;
                if (out_img[r][c] === PIX_FG) nfg++;
            end
        check({tag, "_img"},   32'(mism),    32'd0);
        check({tag, "_fgcnt"}, 32'(nfg),     32'(exp_fg));
        check({tag, "_npix"},  32'(cap_cnt), 32'(c_row * c_col));
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation exceeded time limit");
        $fatal(1);
    end

    initial begin
        vif.RGB_de = 1'b0; vif.RGB_hsync = 1'b0; vif.RGB_vsync = 1'b0; vif.RGB_data = 24'd0;
        repeat (4) @(posedge clk);
        #1;
        check("reset_de",    32'(vif.dilate_de),    32'd0);
        check("reset_hsync", 32'(vif.dilate_hsync), 32'd0);
        check("reset_vsync", 32'(vif.dilate_vsync), 32'd0);
        check("reset_data",  32'(vif.dilate_data),  32'd0);
        rst_n = 1'b1;
        idle(3);

        // Single pixel in the interior.
        fill_img(PIX_BG); in_img[10][10] = PIX_FG;
        send_frame(1'b0);
        check_frame("t1", 9);
        check("t1_px_11_11", 32'(out_img[11][11]), 32'(PIX_FG));
        check("t1_px_9_10",  32'(out_img[9][10]),  32'(PIX_BG));
        check("t1_px_10_13", 32'(out_img[10][13]), 32'(PIX_BG));

        // Uniform frames.
        fill_img(PIX_BG);
        send_frame(1'b0);
        check_frame("t2_zero", 0);
        fill_img(PIX_FG);
        send_frame(1'b0);
        check_frame("t2_ones", c_row * c_col);
        check("t2_px_0_0", 32'(out_img[0][0]), 32'(PIX_FG));

        // Borders: top-left, right edge (no line wrap), bottom-right then clean frame.
        fill_img(PIX_BG); in_img[0][0] = PIX_FG;
        send_frame(1'b0);
        check_frame("t3_tl", 9);
        fill_img(PIX_BG); in_img[5][c_col-1] = PIX_FG;
        send_frame(1'b0);
        check_frame("t3_re", 3);
        check("t3_px_6_0",  32'(out_img[6][0]),       32'(PIX_BG));
        check("t3_px_6_1",  32'(out_img[6][1]),       32'(PIX_BG));
        check("t3_px_7_15", 32'(out_img[7][c_col-1]), 32'(PIX_FG));
        fill_img(PIX_BG); in_img[c_row-1][c_col-1] = PIX_FG;
        send_frame(1'b0);
        check_frame("t3_br", 1);
        fill_img(PIX_BG);
        send_frame(1'b0);
        check_frame("t3_next", 0);

        // Random de gaps inside lines.
        fill_img(PIX_BG); in_img[10][10] = PIX_FG;
        send_frame(1'b1);
        check_frame("t4_gaps", 9);
        check("t4_sync_delay", 32'(sync_err), 32'd0);
        check("de_gating",     32'(gate_err), 32'd0);

        // Asynchronous reset mid-frame, then a fresh frame.
        sync_chk_en = 1'b0;
        fill_img(PIX_BG);
        for (int r = 5; r < 8; r++)
            for (int c = 0; c < 5; c++) in_img[r][c] = PIX_FG;
        send_frame(1'b0, 7, 5);
        fill_img(PIX_BG); in_img[1][1] = PIX_FG;
        send_frame(1'b0);
        check_frame("t5_post_rst", 9);
        check("t5_px_0_1", 32'(out_img[0][1]), 32'(PIX_BG));

        // Foreground decision.
`ifdef DILATE_THRESH_EN
        fill_img(PIX_BG); in_img[4][4] = 24'h7F7F7F;
        send_frame(1'b0);
        check_frame("t6_7f", 0);
        fill_img(PIX_BG); in_img[4][4] = 24'h808080;
        send_frame(1'b0);
        check_frame("t6_80", 9);
`else
        fill_img(PIX_BG); in_img[4][4] = 24'h010101;
        send_frame(1'b0);
        check_frame("t6_01", 9);
        check("t6_px_6_6", 32'(out_img[6][6]), 32'(PIX_FG));
`endif

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
`default_nettype wire
